// File: rtl/issue_buffer.sv
// rtl/issue_buffer.sv - 4-entry fetch-pair buffer issuing to even/odd decode pipes
// Optional dual issue of mixed-pipe pairs is enabled by defining ISSUE_DUAL_EN.
module issue_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fe_valid,
  output logic        fe_ready,
  input  logic [0:31] fe_inst0,
  input  logic [0:31] fe_inst1,
  input  logic        fe_pipe0,
  input  logic        fe_pipe1,
  input  logic [0:31] fe_pc,
  input  logic        dep_stall,
  input  logic        flush,
  output logic [0:31] inst_ep,
  output logic [0:31] inst_op,
  output logic [0:31] pc_ep,
  output logic [0:31] pc_op,
  output logic [2:0]  ib_count
);

  localparam logic [0:31] NOP_WORD  = 32'h4020_0000;
  localparam logic [0:31] LNOP_WORD = 32'h0020_0000;

  logic [0:31] m_inst0 [0:3];
  logic [0:31] m_inst1 [0:3];
  logic [0:31] m_pc    [0:3];
  logic        m_pipe0 [0:3];
  logic        m_pipe1 [0:3];

  logic [1:0]  wr_ptr, rd_ptr;
  logic        head_half;
  logic        push, pop, issue_en, dual_ok;

  logic [0:31] h_inst0, h_inst1, h_pc, h_pc1;
  logic        h_pipe0, h_pipe1;

  logic [0:31] real_inst, real_pc;
  logic        real_pipe;
  logic [0:31] nxt_ep, nxt_op, nxt_pc_ep, nxt_pc_op;

  assign h_inst0 = m_inst0[rd_ptr];
  assign h_inst1 = m_inst1[rd_ptr];
  assign h_pc    = m_pc[rd_ptr];
  assign h_pc1   = h_pc + 32'd4;
  assign h_pipe0 = m_pipe0[rd_ptr];
  assign h_pipe1 = m_pipe1[rd_ptr];

`ifdef ISSUE_DUAL_EN
  assign dual_ok = (h_pipe0 != h_pipe1) && !head_half;
`else
  assign dual_ok = 1'b0;
`endif

  // fe_ready depends only on the registered count, never on stall or flush
  assign fe_ready = (ib_count != 3'd4);
  assign push     = fe_valid && fe_ready && !flush;
  assign issue_en = !flush && !dep_stall && (ib_count != 3'd0);
  assign pop      = issue_en && (head_half || dual_ok);

  always_comb begin
    real_inst = head_half ? h_inst1 : h_inst0;
    real_pipe = head_half ? h_pipe1 : h_pipe0;
    real_pc   = head_half ? h_pc1   : h_pc;
    nxt_ep    = NOP_WORD;
    nxt_op    = LNOP_WORD;
    nxt_pc_ep = real_pc;
    nxt_pc_op = real_pc;
    if (dual_ok) begin
      nxt_ep    = h_pipe0 ? h_inst1 : h_inst0;
      nxt_op    = h_pipe0 ? h_inst0 : h_inst1;
      nxt_pc_ep = h_pipe0 ? h_pc1   : h_pc;
      nxt_pc_op = h_pipe0 ? h_pc    : h_pc1;
    end else if (real_pipe) begin
      nxt_op = real_inst;
    end else begin
      nxt_ep = real_inst;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers/count
  always_ff @(posedge clk) begin
    if (push) begin
      m_inst0[wr_ptr] <= fe_inst0;
      m_inst1[wr_ptr] <= fe_inst1;
      m_pc[wr_ptr]    <= fe_pc;
      m_pipe0[wr_ptr] <= fe_pipe0;
      m_pipe1[wr_ptr] <= fe_pipe1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      ib_count  <= 3'd0;
      head_half <= 1'b0;
      inst_ep   <= NOP_WORD;
      inst_op   <= LNOP_WORD;
      pc_ep     <= 32'd0;
      pc_op     <= 32'd0;
    end else if (flush) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      ib_count  <= 3'd0;
      head_half <= 1'b0;
      inst_ep   <= NOP_WORD;
      inst_op   <= LNOP_WORD;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)
        ib_count <= ib_count + 3'd1;
      else if (pop && !push)
        ib_count <= ib_count - 3'd1;
      if (!dep_stall) begin
        if (ib_count == 3'd0) begin
          inst_ep <= NOP_WORD;
          inst_op <= LNOP_WORD;
        end else begin
          inst_ep   <= nxt_ep;
          inst_op   <= nxt_op;
          pc_ep     <= nxt_pc_ep;
          pc_op     <= nxt_pc_op;
          head_half <= !head_half && !dual_ok;
        end
      end
    end
  end

endmodule
